hsv_to_rgb: RTL and testbench

HSV_TO_RGB -- requirements
Module: hsv_to_rgb

---
 rtl/isp_pkg.sv | 29 ++
 rtl/hsv_to_rgb_sector_mux.sv | 54 +++++
 rtl/hsv_to_rgb.sv | 160 ++++++++++++++++
 tb/tb_hsv_to_rgb.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/isp_pkg.sv
// ============================================================================
// Module  : isp_pkg
// Brief   : Shared ISP constants: channel indices, pipeline depth, helpers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package isp_pkg;

    localparam int CH_H = 2;
    localparam int CH_S = 1;
    localparam int CH_V = 0;
    localparam int CH_R = 2;
    localparam int CH_G = 1;
    localparam int CH_B = 0;

    localparam int CHAN_W     = 8;
    localparam int PIPE_DEPTH = 5;

    // 8x8 multiply keeping the upper byte (truncating divide by 256)
    function automatic logic [7:0] mul_shr8(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] prod;
        prod = {8'd0, x} * {8'd0, y};
        return prod[15:8];
    endfunction

endpackage

`default_nettype wire

// File: rtl/hsv_to_rgb_sector_mux.sv
// ============================================================================
// Module  : hsv_sector_mux
// Brief   : Registered HSV sector selection of (V, p, q, t) into R, G, B.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hsv_sector_mux
    import isp_pkg::*;
(
    input  logic        clk,
    input  logic        en,
    input  logic [2:0]  sector,
    input  logic [7:0]  v,
    input  logic [7:0]  p,
    input  logic [7:0]  q,
    input  logic [7:0]  t,
    input  logic        s_zero,
    output logic [23:0] rgb
);

    logic [7:0] w_r;
    logic [7:0] w_g;
    logic [7:0] w_b;

    always_comb begin
        w_r = v;
        w_g = v;
        w_b = v;
        // Zero saturation is pure grey whatever the hue
        if (!s_zero) begin
            case (sector)
                3'd0:    begin w_r = v; w_g = t; w_b = p; end
                3'd1:    begin w_r = q; w_g = v; w_b = p; end
                3'd2:    begin w_r = p; w_g = v; w_b = t; end
                3'd3:    begin w_r = p; w_g = q; w_b = v; end
                3'd4:    begin w_r = t; w_g = p; w_b = v; end
                3'd5:    begin w_r = v; w_g = p; w_b = q; end
                default: begin w_r = v; w_g = v; w_b = v; end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            rgb[CH_R*CHAN_W +: CHAN_W] <= w_r;
            rgb[CH_G*CHAN_W +: CHAN_W] <= w_g;
            rgb[CH_B*CHAN_W +: CHAN_W] <= w_b;
        end
    end

endmodule

`default_nettype wire

// File: rtl/hsv_to_rgb.sv
// ============================================================================
// Module  : hsv_to_rgb
// Brief   : 5-stage HSV to RGB pixel converter with valid/ready stalling.
//           Optional macro HSV_TO_RGB_CTRL_EN adds isp_ctrl bypass control.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hsv_to_rgb
    import isp_pkg::*;
#(
    parameter int HSV_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [3*HSV_DEPTH-1:0] in_data,
    input  logic [7:0]             in_user,
    output logic                   out_valid,
    output logic [3*HSV_DEPTH-1:0] out_data,
    output logic [7:0]             out_user,
    input  logic                   in_ready,
    output logic                   out_ready
`ifdef HSV_TO_RGB_CTRL_EN
    ,
    input  logic [15:0]            isp_ctrl
`endif
);

    logic                   w_running;
    logic                   w_conv_en;
    logic [PIPE_DEPTH-1:0]  r_valid;
    logic [7:0]             r_user [0:PIPE_DEPTH-2];

    logic [7:0]  w_h;
    logic [7:0]  w_s;
    logic [7:0]  w_v;
    logic [10:0] w_h6;

    // Stage 1
    logic [2:0]             r1_sector;
    logic [7:0]             r1_f;
    logic [7:0]             r1_s;
    logic [7:0]             r1_v;
    logic                   r1_en;
    logic [3*HSV_DEPTH-1:0] r1_bypass;
    // Stage 2
    logic [2:0]             r2_sector;
    logic [7:0]             r2_a;
    logic [7:0]             r2_b;
    logic [7:0]             r2_c;
    logic [7:0]             r2_v;
    logic                   r2_s_zero;
    logic                   r2_en;
    logic [3*HSV_DEPTH-1:0] r2_bypass;
    // Stage 3
    logic [2:0]             r3_sector;
    logic [7:0]             r3_p;
    logic [7:0]             r3_q;
    logic [7:0]             r3_t;
    logic [7:0]             r3_v;
    logic                   r3_s_zero;
    logic                   r3_en;
    logic [3*HSV_DEPTH-1:0] r3_bypass;
    // Stage 4
    logic [23:0]            w_rgb4;
    logic                   r4_en;
    logic [3*HSV_DEPTH-1:0] r4_bypass;

    // A full output register that nobody takes blocks the whole pipe
    assign w_running = in_ready | ~r_valid[PIPE_DEPTH-1];
    assign out_ready = w_running;
    assign out_valid = r_valid[PIPE_DEPTH-1];

`ifdef HSV_TO_RGB_CTRL_EN
    logic r_ctrl_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl_en <= 1'b0;
        end else begin
            r_ctrl_en <= isp_ctrl[0] & isp_ctrl[10];
        end
    end

    assign w_conv_en = r_ctrl_en;
`else
    assign w_conv_en = 1'b1;
`endif

    assign w_h  = in_data[CH_H*CHAN_W +: CHAN_W];
    assign w_s  = in_data[CH_S*CHAN_W +: CHAN_W];
    assign w_v  = in_data[CH_V*CHAN_W +: CHAN_W];
    // 255*6 = 1530 keeps the top bits at most 5, so hue wraps without a sector 6
    assign w_h6 = {3'd0, w_h} * 11'd6;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid  <= '0;
            out_user <= '0;
            out_data <= '0;
        end else if (w_running) begin
            r_valid  <= {r_valid[PIPE_DEPTH-2:0], in_valid};
            out_user <= r_user[PIPE_DEPTH-2];
            out_data <= r4_en ? w_rgb4 : r4_bypass;
        end
    end

    always_ff @(posedge clk) begin
        if (w_running) begin
            r_user[0] <= in_user;
            for (int i = 1; i < PIPE_DEPTH-1; i++) begin
                r_user[i] <= r_user[i-1];
            end

            r1_sector <= w_h6[10:8];
            r1_f      <= w_h6[7:0];
            r1_s      <= w_s;
            r1_v      <= w_v;
            r1_en     <= w_conv_en;
            r1_bypass <= in_data;

            r2_sector <= r1_sector;
            r2_a      <= mul_shr8(r1_s, r1_f);
            r2_b      <= mul_shr8(r1_s, 8'd255 - r1_f);
            r2_c      <= 8'd255 - r1_s;
            r2_v      <= r1_v;
            r2_s_zero <= (r1_s == 8'd0);
            r2_en     <= r1_en;
            r2_bypass <= r1_bypass;

            r3_sector <= r2_sector;
            r3_p      <= mul_shr8(r2_v, r2_c);
            r3_q      <= mul_shr8(r2_v, 8'd255 - r2_a);
            r3_t      <= mul_shr8(r2_v, 8'd255 - r2_b);
            r3_v      <= r2_v;
            r3_s_zero <= r2_s_zero;
            r3_en     <= r2_en;
            r3_bypass <= r2_bypass;

            r4_en     <= r3_en;
            r4_bypass <= r3_bypass;
        end
    end

    hsv_sector_mux u_sector_mux (
        .clk    (clk),
        .en     (w_running),
        .sector (r3_sector),
        .v      (r3_v),
        .p      (r3_p),
        .q      (r3_q),
        .t      (r3_t),
        .s_zero (r3_s_zero),
        .rgb    (w_rgb4)
    );

endmodule

`default_nettype wire

// File: tb/tb_hsv_to_rgb.sv
// ============================================================================
// Module  : tb_hsv_to_rgb
// Brief   : Scoreboard bench for hsv_to_rgb (honours HSV_TO_RGB_CTRL_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hsv_to_rgb;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [23:0] in_data;
    logic [7:0]  in_user;
    logic        out_valid;
    logic [23:0] out_data;
    logic [7:0]  out_user;
    logic        in_ready;
    logic        out_ready;
`ifdef HSV_TO_RGB_CTRL_EN
    logic [15:0] isp_ctrl;
`endif

    typedef struct {
        logic [23:0] data;
        logic [7:0]  user;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    bit          check_lat = 1'b1;
    bit          exp_conv = 1'b1;
    bit          hold_pending = 1'b0;
    logic [23:0] held_data;
    logic [7:0]  held_user;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hsv_to_rgb #(.HSV_DEPTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_user   (in_user),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_user  (out_user),
        .in_ready  (in_ready),
        .out_ready (out_ready)
`ifdef HSV_TO_RGB_CTRL_EN
        ,
        .isp_ctrl  (isp_ctrl)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] model(input int h, input int s, input int v);
        int h6, sec, f, a, b, c, p, q, t, r, g, bl;
        h6 = h * 6;
        sec = h6 / 256;
        f = h6 % 256;
        a = (s * f) / 256;
        b = (s * (255 - f)) / 256;
        c = 255 - s;
        p = (v * c) / 256;
        q = (v * (255 - a)) / 256;
        t = (v * (255 - b)) / 256;
        r = v; g = v; bl = v;
        if (s != 0) begin
            case (sec)
                0: begin r = v; g = t; bl = p; end
                1: begin r = q; g = v; bl = p; end
                2: begin r = p; g = v; bl = t; end
                3: begin r = p; g = q; bl = v; end
                4: begin r = t; g = p; bl = v; end
                default: begin r = v; g = p; bl = q; end
            endcase
        end
        return {8'(r), 8'(g), 8'(bl)};
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (hold_pending) begin
                    check("hold_valid", {31'd0, out_valid}, 32'd1);
                    check("hold_data", {8'd0, out_data}, {8'd0, held_data});
                    check("hold_user", {24'd0, out_user}, {24'd0, held_user});
                    hold_pending = 1'b0;
                end
                if (in_valid && out_ready) begin
                    e.data = exp_conv ? model(in_data[23:16], in_data[15:8], in_data[7:0]) : in_data;
                    e.user = in_user;
                    e.cyc  = cyc;
                    sb.push_back(e);
                end
                if (out_valid && in_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_out", {31'd0, out_valid}, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("out_data", {8'd0, out_data}, {8'd0, e.data});
                        check("out_user", {24'd0, out_user}, {24'd0, e.user});
                        if (check_lat) check("latency", cyc - e.cyc, 32'd5);
                    end
                end
                if (out_valid && !in_ready) begin
                    check("stall_ready", {31'd0, out_ready}, 32'd0);
                    hold_pending = 1'b1;
                    held_data = out_data;
                    held_user = out_user;
                end
            end
        end
    endtask

    task automatic send(input logic [7:0] h, input logic [7:0] s, input logic [7:0] v,
                        input logic [7:0] u);
        in_valid = 1'b1;
        in_data  = {h, s, v};
        in_user  = u;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (out_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        check("send_timeout", {31'd0, out_ready}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 100; k++) begin
            if (sb.size() == 0) break;
            @(posedge clk); #1;
        end
        check("drain", sb.size(), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_ready = 1'b1;
        in_data  = '0;
        in_user  = '0;
`ifdef HSV_TO_RGB_CTRL_EN
        isp_ctrl = 16'h0401;
`endif
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {8'd0, out_data}, 32'd0);
        check("rst_user", {24'd0, out_user}, 32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_ready", {31'd0, out_ready}, 32'd1);

        // Red primary, grey at three hues, sector 1 edge, hue wrap
        send(8'd0, 8'd255, 8'd255, 8'd1);
        drain();
        send(8'd0, 8'd0, 8'd100, 8'd2);
        send(8'd77, 8'd0, 8'd100, 8'd3);
        send(8'd255, 8'd0, 8'd100, 8'd4);
        send(8'd85, 8'd255, 8'd255, 8'd5);
        send(8'd255, 8'd200, 8'd180, 8'd6);
        drain();

        for (int i = 0; i < 20; i++) begin
            send(8'($urandom_range(255)), 8'($urandom_range(255)),
                 8'($urandom_range(255)), 8'(i + 16));
        end
        drain();

        // Burst of 8 with a 3-cycle downstream stall in the middle
        check_lat = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(8'(i * 37), 8'(255 - i * 20), 8'(200 + i), 8'(i));
                end
            end
            begin
                repeat (6) @(posedge clk);
                #1 in_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 in_ready = 1'b1;
            end
        join
        drain();
        check_lat = 1'b1;

        // Reset with three pixels in flight; none of them may emerge
        send(8'd10, 8'd100, 8'd150, 8'hA0);
        send(8'd50, 8'd100, 8'd150, 8'hA1);
        send(8'd90, 8'd100, 8'd150, 8'hA2);
        reset = 1'b1;
        @(posedge clk); #1;
        sb.delete();
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_data", {8'd0, out_data}, 32'd0);
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        send(8'd128, 8'd255, 8'd255, 8'hB0);
        drain();

`ifdef HSV_TO_RGB_CTRL_EN
        isp_ctrl = 16'h0001;
        exp_conv = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        send(8'd10, 8'd20, 8'd30, 8'hC0);
        drain();
        isp_ctrl = 16'h0401;
        exp_conv = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        send(8'd10, 8'd20, 8'd30, 8'hC1);
        drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
